fetch_predict: RTL

//  Instruction-fetch stage with dynamic branch prediction: the producer side of the decoder

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_predict_bht.sv | 30 +++
 rtl/fetch_predict.sv | 105 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/predict stage: BHT counter type,
// its reset/saturation values, and the opcode codes fetch needs to recognise.
package fetch_pkg;
  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t   BHT_INIT = 2'b01;
  localparam bht_ctr_t   CTR_MAX  = 2'b11;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_BLT   = 4'h9;

  // 2-bit saturating counter step toward taken/not-taken
  function automatic bht_ctr_t ctr_step(bht_ctr_t c, logic taken);
    if (taken) return (c == CTR_MAX) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction
endpackage

// File: rtl/fetch_predict_bht.sv
// Branch history table: 2**BHTW two-bit counters, one combinational read port
// for fetch and one synchronous saturating update port for the ID stage.
module fetch_predict_bht
  import fetch_pkg::*;
#(
  parameter int BHTW = 4
) (
  input  logic            clk,
  input  logic            nReset,
  input  logic [BHTW-1:0] rd_idx_i,
  output bht_ctr_t        rd_ctr_o,
  input  logic            upd_en_i,
  input  logic [BHTW-1:0] upd_idx_i,
  input  logic            upd_taken_i
);
  localparam int NENT = 1 << BHTW;

  bht_ctr_t ctr_q [NENT];

  // No write-to-read bypass: a same-cycle update is seen by fetch one cycle later
  assign rd_ctr_o = ctr_q[rd_idx_i];

  always_ff @(posedge clk) begin
    if (!nReset) begin
      for (int i = 0; i < NENT; i++) ctr_q[i] <= BHT_INIT;
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= ctr_step(ctr_q[upd_idx_i], upd_taken_i);
    end
  end
endmodule

// File: rtl/fetch_predict.sv
// Instruction fetch with BHT-based BLT prediction: PC generation, IF/ID register,
// ID-stage mispredict detection, one-bubble flush and redirect.
module fetch_predict
  import fetch_pkg::*;
#(
  parameter int PWIDTH = 6,
  parameter int IWIDTH = 20,
  parameter int OFFW   = 8,
  parameter int BHTW   = 4
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              stall,
  input  logic [IWIDTH-1:0] instr,
  output logic [PWIDTH-1:0] pc,
  output logic [IWIDTH-1:0] id_instr,
  output logic [3:0]        id_opcode,
  output logic [PWIDTH-1:0] id_pc,
  output logic              id_valid,
  output logic              id_pred_taken,
  input  logic              branch_actual,
  output logic              mispredict,
  output logic [7:0]        mispred_cnt
);
  localparam logic [IWIDTH-1:0] NOP_WORD = {OP_NOP, {(IWIDTH-4){1'b0}}};

  logic [PWIDTH-1:0] pc_q, pc_d, id_pc_q, id_pc_d;
  logic [IWIDTH-1:0] id_instr_q, id_instr_d;
  logic              id_valid_q, id_valid_d, id_pred_q, id_pred_d;
  logic [7:0]        cnt_q, cnt_d;

  bht_ctr_t          if_ctr;
  logic              if_blt, if_pred, id_blt;
  logic [PWIDTH-1:0] if_target, redirect;

  assign if_blt    = (instr[IWIDTH-1 -: 4] == OP_BLT);
  assign if_pred   = if_blt & if_ctr[1];
  assign if_target = pc_q + PWIDTH'($signed(instr[OFFW-1:0]));

  assign id_blt     = id_valid_q & (id_instr_q[IWIDTH-1 -: 4] == OP_BLT);
  assign mispredict = id_blt & (branch_actual != id_pred_q) & ~stall;
  assign redirect   = branch_actual ? id_pc_q + PWIDTH'($signed(id_instr_q[OFFW-1:0]))
                                    : id_pc_q + PWIDTH'(1);

  fetch_predict_bht #(.BHTW(BHTW)) u_bht (
    .clk         (clk),
    .nReset      (nReset),
    .rd_idx_i    (pc_q[BHTW-1:0]),
    .rd_ctr_o    (if_ctr),
    .upd_en_i    (id_blt & ~stall),
    .upd_idx_i   (id_pc_q[BHTW-1:0]),
    .upd_taken_i (branch_actual)
  );

  always_comb begin
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    id_pred_d  = id_pred_q;
    cnt_d      = cnt_q;
    if (!stall) begin
      if (mispredict) begin
        // Squash the wrong-path word fetched this cycle
        pc_d       = redirect;
        id_instr_d = NOP_WORD;
        id_valid_d = 1'b0;
        id_pred_d  = 1'b0;
        cnt_d      = cnt_q + {7'd0, cnt_q != 8'hFF};
      end else begin
        pc_d       = if_pred ? if_target : pc_q + PWIDTH'(1);
        id_instr_d = instr;
        id_pc_d    = pc_q;
        id_valid_d = 1'b1;
        id_pred_d  = if_pred;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      pc_q       <= '0;
      id_instr_q <= NOP_WORD;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      id_pred_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      id_pred_q  <= id_pred_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc            = pc_q;
  assign id_instr      = id_instr_q;
  assign id_opcode     = id_instr_q[IWIDTH-1 -: 4];
  assign id_pc         = id_pc_q;
  assign id_valid      = id_valid_q;
  assign id_pred_taken = id_pred_q;
  assign mispred_cnt   = cnt_q;
endmodule
